// File: rtl/key_switch_conditioner.sv
// Board input conditioning: 2-flop synchronisers on keys and switches, plus a
// debounce FSM per key producing clean levels and one-cycle press/release strobes.

module ksc_key_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic p,
  output logic level,
  output logic level_n,
  output logic press,
  output logic rel
);
  typedef enum logic [1:0] {IDLE, PRESS_W, PRESSED, REL_W} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      level_n <= 1'b1;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: if (p) begin
          state <= PRESS_W;
          cnt   <= CNT_ONE;
        end
        // any contrary sample, including on the last counting cycle, restarts
        PRESS_W: if (!p) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
          state   <= PRESSED;
          cnt     <= '0;
          press   <= 1'b1;
          level   <= 1'b1;
          level_n <= 1'b0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
        PRESSED: if (!p) begin
          state <= REL_W;
          cnt   <= CNT_ONE;
        end
        REL_W: if (p) begin
          state <= PRESSED;
          cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
          state   <= IDLE;
          cnt     <= '0;
          rel     <= 1'b1;
          level   <= 1'b0;
          level_n <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module key_switch_conditioner #(
  parameter  int N_KEYS          = 2,
  parameter  int N_SW            = 8,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_n_raw,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_level_n,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_SW-1:0]   sw_sync
);
  // keys idle high (released), so their synchronisers reset to 1
  logic [1:0][N_KEYS-1:0] key_pipe;
  logic [1:0][N_SW-1:0]   sw_pipe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_pipe <= '1;
      sw_pipe  <= '0;
    end else begin
      key_pipe <= {key_pipe[0], key_n_raw};
      sw_pipe  <= {sw_pipe[0], sw_raw};
    end
  end

  assign sw_sync = sw_pipe[1];

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    ksc_key_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .Clk    (Clk),
      .Reset  (Reset),
      .p      (~key_pipe[1][g]),
      .level  (key_level[g]),
      .level_n(key_level_n[g]),
      .press  (key_press[g]),
      .rel    (key_release[g])
    );
  end
endmodule
